// File: rtl/latch_chain_writer.sv
// latch_chain_writer: serialises a captured parallel word into a chain of
// level-sensitive gated D latches. Each bit is presented as a
// SETUP / GATE / HOLD sequence so that d_out is stable for a full cycle
// before the gate rises and after it falls. d_out changes only on the
// clock edge that enters SETUP.
// Optional feature macro: LCW_PARITY_EN. When it is defined, one extra
// even-parity bit (XOR of the captured word) is sent after the data bits.
module latch_chain_writer #(
  parameter int WIDTH       = 8,
  parameter int GATE_CYCLES = 1,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             d_out,
  output logic             g_out,
  output logic             busy,
  output logic             done
);

`ifdef LCW_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif

  // The bit counter can hold NBITS and the gate counter GATE_CYCLES without wrap.
  localparam int CW = $clog2(NBITS + 1);
  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NBITS - 1);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GATE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic             data_bit;
  logic             cur_bit;

`ifdef LCW_PARITY_EN
  localparam logic [CW-1:0] PAR_IDX = CW'(WIDTH);
  logic parity_q, parity_d;
`endif

  // Bit currently on the wire: head of the shift register, or parity last.
  always_comb begin
    data_bit = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
`ifdef LCW_PARITY_EN
    cur_bit = (bit_cnt_q == PAR_IDX) ? parity_q : data_bit;
`else
    cur_bit = data_bit;
`endif
  end

  // Next-state logic: handshake capture, per-bit sequencing and bit advance.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gate_cnt_d = gate_cnt_q;
`ifdef LCW_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          shreg_d    = data_in;
          bit_cnt_d  = '0;
          gate_cnt_d = '0;
`ifdef LCW_PARITY_EN
          // Parity comes from the captured word, never from live data_in.
          parity_d   = ^data_in;
`endif
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        gate_cnt_d = '0;
        state_d    = S_GATE;
      end
      S_GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          state_d = S_HOLD;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (bit_cnt_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          // Advancing here makes the new bit appear on the SETUP entry edge.
          bit_cnt_d = bit_cnt_q + 1'b1;
          shreg_d   = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          state_d   = S_SETUP;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset that aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gate_cnt_q <= '0;
`ifdef LCW_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gate_cnt_q <= gate_cnt_d;
`ifdef LCW_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // Outputs decoded from registered state only; no path from load_valid.
  always_comb begin
    load_ready = (state_q == S_IDLE);
    busy       = (state_q == S_SETUP) || (state_q == S_GATE) || (state_q == S_HOLD);
    g_out      = (state_q == S_GATE);
    done       = (state_q == S_DONE);
    d_out      = busy & cur_bit;
  end

endmodule

// File: doc/latch_chain_writer.md
Name: latch_chain_writer

Overview:
- Serial writer that loads a chain of level-sensitive gated D latches, one bit at a time.
- Captures a parallel word through a valid/ready handshake.
- For each bit, drives a data line and a gate strobe with guaranteed setup and hold around the gate pulse.
- Sits between a parallel producer and the team's NAND-based latch cells, which take a data input and a gate input.

Parameters:
WIDTH, 8, bits per word (>=1)
GATE_CYCLES, 1, clocks g_out stays high per bit (>=1)
LSB_FIRST, 1, 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  WIDTH  parallel word, sampled only on handshake
load_valid  input  1  producer has a word
load_ready  output  1  writer can accept a word
d_out  output  1  serial data to latch d input
g_out  output  1  gate strobe to latch gate input
busy  output  1  high while any bit is in flight
done  output  1  one-cycle pulse after the last bit's hold phase

Behaviour:
- Reset (rst=1 at a rising edge) sets state=IDLE and clears the shift register, bit counter and gate counter.
- Outputs after reset: load_ready=1, d_out=0, g_out=0, busy=0, done=0. rst takes priority over every other input.
- States: IDLE, SETUP, GATE, HOLD, DONE. All outputs are registered or decoded from state only; there is no combinational path from load_valid to load_ready.
- IDLE:
  - load_ready=1.
  - If load_valid=1 at a rising edge: capture data_in into the shift register, clear the bit counter, go to SETUP.
  - d_out=0, g_out=0.
- SETUP (1 cycle): d_out=current bit, g_out=0, go to GATE with gate counter=0.
- GATE (exactly GATE_CYCLES cycles): d_out=current bit, g_out=1.
- HOLD (1 cycle):
  - d_out=current bit (unchanged), g_out=0.
  - If this was the last bit, go to DONE; otherwise advance the bit (shift or counter) and go to SETUP.
- DONE (1 cycle): done=1, d_out=0, g_out=0, load_ready=0, go to IDLE.
- busy=1 in SETUP/GATE/HOLD; 0 in IDLE/DONE.
- load_ready=0 in every state except IDLE.
- d_out never changes in the same cycle g_out rises or falls; it changes only on the SETUP entry edge.
- Timing: accept at edge k puts the first SETUP in cycle k+1. done is high in cycle k+1+N*(GATE_CYCLES+2), where N = number of bits sent.
- Minimum spacing between two accepted words: N*(GATE_CYCLES+2)+2 cycles.
- load_valid while not in IDLE: ignored, nothing captured, the in-flight word is unaffected. data_in changes after capture have no effect.
- Reset mid-word (any state): next cycle is IDLE with g_out=0 and d_out=0. No done pulse and no partial completion.
- WIDTH=1: a single SETUP/GATE/HOLD sequence, then DONE.
- Counters are sized to hold WIDTH (+1 with the optional feature) and GATE_CYCLES without wrap. Bit order follows LSB_FIRST for data bits.

Optional Feature:
- Macro: LCW_PARITY_EN.
- When defined:
  - After the data bits, one extra bit is sent with its own SETUP/GATE/HOLD sequence: even parity = XOR of all captured data bits.
  - N=WIDTH+1. The parity bit is always last regardless of LSB_FIRST.
  - Parity is computed from the captured word, not from live data_in.
- When undefined: N=WIDTH, no parity logic is present, and port list and timing are otherwise identical.

Test Plan:
1. Reset, then idle with load_valid=0 -> load_ready=1, d_out=0, g_out=0, busy=0, done=0 held for 10 cycles.
2. WIDTH=8, GATE_CYCLES=1, LSB_FIRST=1; accept 8'hA5 at edge k:
   - d_out sequence 1,0,1,0,0,1,0,1.
   - g_out high in cycles k+2, k+5, …, k+23 (one cycle each).
   - d_out stable one cycle either side of each g_out pulse.
   - done=1 only in cycle k+25.
3. Same word with LSB_FIRST=0, GATE_CYCLES=3:
   - d_out sequence 1,0,1,0,0,1,0,1 (MSB first; pattern is symmetric).
   - Each g_out pulse lasts 3 cycles.
   - done in cycle k+1+40.
   - Repeat with 8'h01 -> first bit 0 and last bit 1.
4. Hold load_valid=1 with data_in toggling 8'h00/8'hFF every cycle during a transfer of 8'h3C -> only 8'h3C is serialized; the next word is accepted in the first IDLE cycle after done, captured at that edge.
5. Assert rst for 1 cycle while in GATE of bit 4 -> next cycle IDLE, g_out=0, no done. A new word 8'hF0 then serializes correctly from bit 0.
6. With LCW_PARITY_EN, send 8'h07 -> 9 gate pulses, last bit 1, done in cycle k+28. Send 8'hA5 -> parity bit 0.
